log2_range_reduce: RTL

// - Sequential front-end stage directly upstream of the float32 log2 polynomial datapath.
// - Accepts one IEEE-754 single x, screens special operands and normalises subnormals (1 bit/cycle).
// - Reduces x to f in [sqrt(2)/2, sqrt(2)) with integer k such that x = f * 2^k.
// - Hands {f, k} or a final special result downstream over a valid/ready handshake.

---
 rtl/log2_range_reduce_if.sv | 26 ++
 rtl/log2_range_reduce.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/log2_range_reduce_if.sv
// Handshake bundle between the log2 range-reduction stage and its neighbours.
// The master side supplies operands and consumes results.
// The slave side is the range-reduction stage itself.
interface log2_range_reduce_if #(
    parameter int K_W = 9
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           x_i;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           f_o;
    logic signed [K_W-1:0] k_o;
    logic                  special_o;
    logic [31:0]           res_o;

    modport master (
        output in_valid, x_i, out_ready,
        input  in_ready, out_valid, f_o, k_o, special_o, res_o
    );

    modport slave (
        input  in_valid, x_i, out_ready,
        output in_ready, out_valid, f_o, k_o, special_o, res_o
    );
endinterface

// File: rtl/log2_range_reduce.sv
// log2_range_reduce: front end of the float32 log2 datapath.
// Screens special operands and reduces x to f * 2^k with f in [sqrt(2)/2, sqrt(2)).
// Subnormals are normalised one bit per cycle.
// Build option LOG2_RR_FTZ_EN: subnormals are flushed to zero (result -inf)
// and the normalisation state and shifter are removed.
module log2_range_reduce #(
    parameter logic [22:0] SQRT2_MANT = 23'h3504f3,
    parameter int          K_W        = 9
) (
    input  logic               clk,
    input  logic               rst_n,
    log2_range_reduce_if.slave bus
);

`ifdef LOG2_RR_FTZ_EN
    typedef enum logic [1:0] {S_IDLE, S_CLASS, S_REDUCE, S_OUT} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_CLASS, S_NORM, S_REDUCE, S_OUT} state_t;
`endif

    localparam logic [31:0] RES_NEG_INF = 32'hff800000;
    localparam logic [31:0] RES_QNAN    = 32'h7fc00000;
    localparam logic [31:0] ONE_F32     = 32'h3f800000;

    state_t                state_q, state_d;
    logic [31:0]           x_q, x_d;
    // Fraction bits only; the leading one is implicit once we reach REDUCE.
    logic [22:0]           frac_q, frac_d;
    logic signed [9:0]     e_q, e_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           f_q, f_d;
    logic signed [K_W-1:0] k_q, k_d;
    logic                  special_q, special_d;
    logic [31:0]           res_q, res_d;
    logic signed [9:0]     k_full;

    // Next-state and next-output computation for the whole FSM.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        frac_d      = frac_q;
        e_d         = e_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        f_d         = f_q;
        k_d         = k_q;
        special_d   = special_q;
        res_d       = res_q;
        k_full      = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    x_d        = bus.x_i;
                    in_ready_d = 1'b0;
                    state_d    = S_CLASS;
                end
            end

            S_CLASS: begin
                // Default to a special result; the normal paths override below.
                special_d = 1'b1;
                f_d       = '0;
                k_d       = '0;
                state_d   = S_OUT;
                if (x_q[30:0] == 31'd0) begin
                    res_d = RES_NEG_INF;
                end else if (x_q[31]) begin
                    res_d = RES_QNAN;
                end else if (x_q[30:23] == 8'hff) begin
                    res_d = x_q;
                end else if (x_q == ONE_F32) begin
                    res_d = 32'h0000_0000;
                end else if (x_q[30:23] == 8'h00) begin
`ifdef LOG2_RR_FTZ_EN
                    res_d = RES_NEG_INF;
`else
                    special_d = 1'b0;
                    res_d     = '0;
                    frac_d    = x_q[22:0];
                    e_d       = 10'sd1;
                    state_d   = S_NORM;
`endif
                end else begin
                    special_d = 1'b0;
                    res_d     = '0;
                    frac_d    = x_q[22:0];
                    e_d       = $signed({2'b00, x_q[30:23]});
                    state_d   = S_REDUCE;
                end
            end

`ifndef LOG2_RR_FTZ_EN
            S_NORM: begin
                // The bit shifted out of frac[22] is the leading one; once it
                // leaves, the mantissa is normalised and frac holds the rest.
                frac_d = {frac_q[21:0], 1'b0};
                e_d    = e_q - 10'sd1;
                if (frac_q[22]) begin
                    state_d = S_REDUCE;
                end
            end
`endif

            S_REDUCE: begin
                special_d = 1'b0;
                res_d     = '0;
                if (frac_q >= SQRT2_MANT) begin
                    f_d    = {1'b0, 8'h7e, frac_q};
                    k_full = e_q - 10'sd126;
                end else begin
                    f_d    = {1'b0, 8'h7f, frac_q};
                    k_full = e_q - 10'sd127;
                end
                k_d     = K_W'(k_full);
                state_d = S_OUT;
            end

            S_OUT: begin
                // First OUT cycle raises valid; the fields were loaded on entry
                // and stay frozen until the downstream handshake.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register; operand working registers carry no reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            f_q         <= '0;
            k_q         <= '0;
            special_q   <= 1'b0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            f_q         <= f_d;
            k_q         <= k_d;
            special_q   <= special_d;
            res_q       <= res_d;
        end
        x_q    <= x_d;
        frac_q <= frac_d;
        e_q    <= e_d;
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.f_o       = f_q;
    assign bus.k_o       = k_q;
    assign bus.special_o = special_q;
    assign bus.res_o     = res_q;

endmodule
